// File: rtl/hdmi_i2c_config_sequencer.sv
// HDMI transmitter power-up register sequencer: walks a fixed write table through
// the I2C master with go/done handshake, retry on NACK/timeout, and hot-plug replay.
`timescale 1ns/1ps
module hdmi_i2c_config_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h72,
  parameter int unsigned POWERUP_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned RETRY_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        hpd,
  output logic        i2c_go,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        config_done,
  output logic        config_error,
  output logic [3:0]  write_index
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PWRUP = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [3:0] LAST_INDEX = 4'd9;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h4110;
      4'd1:    table_entry = 16'h9803;
      4'd2:    table_entry = 16'h9AE0;
      4'd3:    table_entry = 16'h9C30;
      4'd4:    table_entry = 16'h9D61;
      4'd5:    table_entry = 16'hA2A4;
      4'd6:    table_entry = 16'hA3A4;
      4'd7:    table_entry = 16'hE0D0;
      4'd8:    table_entry = 16'hF900;
      4'd9:    table_entry = 16'h1500;
      default: table_entry = '0;
    endcase
  endfunction

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [31:0] retry;
  logic        hpd_s1;
  logic        hpd_s2;
  logic        hpd_s3;
  logic        hpd_rise;

  always_comb begin
    hpd_rise = hpd_s2 & ~hpd_s3;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hpd_s1 <= 1'b0;
      hpd_s2 <= 1'b0;
      hpd_s3 <= 1'b0;
    end else begin
      hpd_s1 <= hpd;
      hpd_s2 <= hpd_s1;
      hpd_s3 <= hpd_s2;
    end
  end

  // i2c_data is preloaded with the next entry whenever the index is set, so it
  // never moves during GAP/ISSUE/WAIT and only changes on WAIT exit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      retry        <= '0;
      i2c_go       <= 1'b0;
      i2c_data     <= '0;
      busy         <= 1'b0;
      config_done  <= 1'b0;
      config_error <= 1'b0;
      write_index  <= '0;
    end else begin
      i2c_go <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_PWRUP;
            cnt         <= POWERUP_CYCLES - 32'd1;
            retry       <= '0;
            write_index <= '0;
            i2c_data    <= {SLAVE_ADDR, table_entry(4'd0)};
            busy        <= 1'b1;
          end
        end
        S_PWRUP: begin
          if (cnt == '0) state <= S_ISSUE;
          else           cnt   <= cnt - 32'd1;
        end
        S_ISSUE: begin
          i2c_go <= 1'b1;
          cnt    <= TIMEOUT_CYCLES - 32'd1;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving in the expiry cycle takes priority over the timeout.
          if (i2c_done && !i2c_nack) begin
            if (write_index == LAST_INDEX) begin
              state       <= S_DONE;
              busy        <= 1'b0;
              config_done <= 1'b1;
            end else begin
              write_index <= write_index + 4'd1;
              i2c_data    <= {SLAVE_ADDR, table_entry(write_index + 4'd1)};
              retry       <= '0;
              cnt         <= GAP_CYCLES - 32'd1;
              state       <= S_GAP;
            end
          end else if (i2c_done || cnt == '0) begin
            if (retry < RETRY_LIMIT) begin
              retry <= retry + 32'd1;
              cnt   <= GAP_CYCLES - 32'd1;
              state <= S_GAP;
            end else begin
              state        <= S_ERROR;
              busy         <= 1'b0;
              config_error <= 1'b1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_ISSUE;
          else           cnt   <= cnt - 32'd1;
        end
        S_DONE, S_ERROR: begin
          if (hpd_rise) begin
            state        <= S_PWRUP;
            cnt          <= POWERUP_CYCLES - 32'd1;
            retry        <= '0;
            write_index  <= '0;
            i2c_data     <= {SLAVE_ADDR, table_entry(4'd0)};
            busy         <= 1'b1;
            config_done  <= 1'b0;
            config_error <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_config_sequencer.sv
// Bench for hdmi_i2c_config_sequencer: randomized-latency I2C responder with fault
// injection, and an expected-write list built from the table and retry rules.
`timescale 1ns/1ps
module tb_hdmi_i2c_config_sequencer;

  localparam int P = 64;
  localparam int G = 16;
  localparam int T = 256;
  localparam int R = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        hpd = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        i2c_go;
  logic [23:0] i2c_data;
  logic        busy;
  logic        config_done;
  logic        config_error;
  logic [3:0]  write_index;

  hdmi_i2c_config_sequencer #(
    .SLAVE_ADDR    (8'h72),
    .POWERUP_CYCLES(P),
    .GAP_CYCLES    (G),
    .TIMEOUT_CYCLES(T),
    .RETRY_LIMIT   (R)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .hpd         (hpd),
    .i2c_go      (i2c_go),
    .i2c_data    (i2c_data),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack),
    .busy        (busy),
    .config_done (config_done),
    .config_error(config_error),
    .write_index (write_index)
  );

  logic [15:0] tbl [10] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
                            16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500};

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int          go_cyc[$];
  logic [23:0] go_data[$];
  int          resp_cyc[$];
  int          stab_bad = 0;
  bit          watching = 0;
  logic [23:0] cur_data;
  logic [3:0]  cur_idx;

  int scen_id = 0;
  int fault_idx = -1;
  int fault_kind = 0;   // 0 none, 1 nack once, 2 nack always, 3 never respond

  logic [23:0] exp_data[$];
  bit          exp_err;
  int          exp_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every go pulse; watch data/index stay put until the matching done.
  always @(negedge clk) begin
    if (!reset_n) begin
      watching = 0;
    end else if (i2c_go) begin
      go_cyc.push_back(cyc);
      go_data.push_back(i2c_data);
      cur_data = i2c_data;
      cur_idx  = write_index;
      watching = 1;
    end else if (watching) begin
      if (i2c_data !== cur_data || write_index !== cur_idx) stab_bad++;
      if (i2c_done) watching = 0;
    end
  end

  // I2C master model: random latency per transaction, faults on one table entry.
  initial begin
    int lat;
    int e;
    int my_scen;
    int hits;
    bit nk;
    my_scen = -1;
    hits = 0;
    forever begin
      @(negedge clk);
      if (i2c_go) begin
        if (scen_id != my_scen) begin
          my_scen = scen_id;
          hits = 0;
        end
        e = -1;
        for (int k = 0; k < 10; k++) if (tbl[k] == i2c_data[15:0]) e = k;
        nk = 1'b0;
        if (e == fault_idx) begin
          hits++;
          if (fault_kind == 3) begin
            resp_cyc.push_back(-1);
            continue;
          end
          nk = (fault_kind == 2) || (fault_kind == 1 && hits == 1);
        end
        lat = $urandom_range(3, 60);
        repeat (lat) @(negedge clk);
        i2c_done = 1'b1;
        i2c_nack = nk;
        resp_cyc.push_back(cyc);
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected writes: each entry once, the faulty one repeated per the retry rules.
  function automatic void build_expect(input int fidx, input int kind);
    int attempts;
    exp_data.delete();
    exp_err = 1'b0;
    exp_idx = 9;
    for (int k = 0; k < 10; k++) begin
      attempts = 1;
      if (k == fidx && kind == 1) attempts = 2;
      if (k == fidx && kind >= 2) attempts = R + 1;
      for (int a = 0; a < attempts; a++) exp_data.push_back({8'h72, tbl[k]});
      if (k == fidx && kind >= 2) begin
        exp_err = 1'b1;
        exp_idx = k;
        break;
      end
    end
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_go"},    i2c_go, 0);
    check({pfx, "_data"},  i2c_data, 0);
    check({pfx, "_busy"},  busy, 0);
    check({pfx, "_done"},  config_done, 0);
    check({pfx, "_error"}, config_error, 0);
    check({pfx, "_index"}, write_index, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  // mode 0: launch with start; mode 1: launch with hpd rise (and toggle hpd mid-run).
  task automatic run(input int fidx, input int kind, input int mode);
    int gb, rb, sb, t0, fin, budget, n, r, tog, tstamp, expfin;
    scen_id++;
    fault_idx = fidx;
    fault_kind = kind;
    build_expect(fidx, kind);
    gb = go_cyc.size();
    rb = resp_cyc.size();
    sb = stab_bad;
    tog = 0;
    tstamp = 0;
    if (mode == 1) begin
      hpd = 1'b0;
      repeat (6) @(negedge clk);
    end
    repeat ($urandom_range(1, 6)) @(negedge clk);
    if (mode == 0) begin
      start = 1'b1;
      t0 = cyc;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start = 1'b0;
    end else begin
      hpd = 1'b1;
      t0 = cyc;
      repeat (2) @(negedge clk);
      check("hpd_busy_early", busy, 0);
      @(negedge clk);
      check("hpd_busy_rise", busy, 1);
    end
    budget = 20000;
    while (budget > 0 && !(config_done || config_error)) begin
      @(negedge clk);
      budget--;
      if (mode == 1) begin
        if (tog == 0 && go_cyc.size() - gb >= 4) begin
          hpd = 1'b0;
          tog = 1;
          tstamp = cyc;
        end else if (tog == 1 && cyc >= tstamp + 8) begin
          hpd = 1'b1;
          tog = 2;
        end
      end
    end
    fin = cyc;
    check("finish_in_budget", budget > 0, 1);
    repeat (150) @(negedge clk);

    n = go_cyc.size() - gb;
    check("go_count", n, exp_data.size());
    for (int j = 0; j < n && j < exp_data.size(); j++) check("go_data", go_data[gb + j], exp_data[j]);
    // Start is sampled on the edge after it is driven, so go lands P+1 edges after that.
    if (n > 0) check("first_go", go_cyc[gb] - t0, (mode == 1) ? P + 4 : P + 2);
    if (n > 0 && resp_cyc.size() >= rb + n) begin
      for (int j = 1; j < n; j++) begin
        r = resp_cyc[rb + j - 1];
        if (r >= 0) check("done_to_go", go_cyc[gb + j] - r, G + 2);
        else        check("timeout_reissue", go_cyc[gb + j] - go_cyc[gb + j - 1], T + G + 1);
      end
      r = resp_cyc[rb + n - 1];
      expfin = (r >= 0) ? r + 1 : go_cyc[gb + n - 1] + T;
      check("final_latency", fin, expfin);
    end else begin
      check("responses_logged", resp_cyc.size() - rb, n);
    end
    check("config_done", config_done, !exp_err);
    check("config_error", config_error, exp_err);
    check("busy_idle", busy, 0);
    check("write_index", write_index, exp_idx);
    check("data_stable", stab_bad - sb, 0);
  endtask

  initial begin
    int gb, budget;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset_n = 1'b1;

    run(-1, 0, 0);
    run(-1, 0, 1);

    do_reset();
    run(3, 1, 0);

    do_reset();
    run(5, 2, 0);
    run(-1, 0, 1);

    do_reset();
    run(0, 3, 0);

    // Reset while entry 7 is outstanding, then replay from entry 0.
    do_reset();
    scen_id++;
    fault_idx = -1;
    fault_kind = 0;
    gb = go_cyc.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 5000;
    while (budget > 0 && go_cyc.size() - gb < 8) begin
      @(negedge clk);
      budget--;
    end
    check("reach_entry7", budget > 0, 1);
    check("entry7_data", go_data[go_data.size() - 1], {8'h72, tbl[7]});
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midwait");
    @(negedge clk);
    reset_n = 1'b1;
    gb = go_cyc.size();
    repeat (80) @(negedge clk);
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_no_go", go_cyc.size() - gb, 0);
    check("post_reset_done", config_done, 0);
    run(-1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_i2c_config_sequencer.md
# hdmi_i2c_config_sequencer

Sequences the HDMI transmitter power-up configuration over the I2C master interface. After a power-up delay it walks a fixed table of register writes, issuing each as a 24-bit {slave, register, data} word to the I2C master with a go/done handshake. NACK and timeout are retried, and permanent failure is flagged. A hot-plug re-detect replays the whole table. Sits between the top-level reset/HPD logic and the I2C master.

## Interface
- SLAVE_ADDR, 8'h72, 8-bit write address of the HDMI transmitter
- POWERUP_CYCLES, 200000, clk cycles waited before the first write (40 ms at 5 MHz)
- GAP_CYCLES, 16, idle clk cycles between consecutive transactions
- TIMEOUT_CYCLES, 4096, max clk cycles waiting for i2c_done; on expiry, treated as NACK
- RETRY_LIMIT, 3, retries per entry after the first attempt
- clk  in  1  system clock (same clock as the I2C master reference)
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  level; sampled in IDLE, begins configuration
- hpd  in  1  asynchronous hot-plug detect; 2-flop synchronised internally
- i2c_go  out  1  one-cycle pulse requesting a transaction
- i2c_data  out  24  {SLAVE_ADDR, reg, value}; stable from the i2c_go cycle until i2c_done
- i2c_done  in  1  one-cycle pulse, transaction finished
- i2c_nack  in  1  valid only with i2c_done; 1 = slave did not acknowledge
- busy  out  1  high in every state except IDLE, DONE, ERROR
- config_done  out  1  high while in DONE
- config_error  out  1  high while in ERROR
- write_index  out  4  table index currently being written

## Operation
- Table: 10 fixed entries, index 0..9, {reg, value}:
  - 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4, A3/A4, E0/D0, F9/00, 15/00
- States: IDLE, PWRUP, ISSUE, WAIT, GAP, DONE, ERROR.
- IDLE -> PWRUP when start=1. Load the delay counter with POWERUP_CYCLES-1. Set write_index=0 and retry count=0.
- PWRUP: count down. At 0 -> ISSUE.
- ISSUE: assert i2c_go for exactly 1 cycle. Drive i2c_data from the table. Load the timeout counter. -> WAIT.
- WAIT, on i2c_done & !i2c_nack:
  - if write_index==9 -> DONE
  - else increment write_index, clear the retry count, -> GAP
- WAIT, on i2c_done & i2c_nack, or timeout counter reaching 0:
  - if retry count < RETRY_LIMIT: increment the retry count, -> GAP, then re-issue the same index
  - else -> ERROR
- GAP: count GAP_CYCLES, then -> ISSUE.
- DONE / ERROR: hold. A rising edge on synchronised hpd -> PWRUP with index 0 and retry count 0. start has no effect in these states.
- hpd edges in any other state are ignored. i2c_done outside WAIT is ignored.
- Reset (any state, mid-transaction included):
  - state IDLE, all counters 0
  - i2c_go=0, i2c_data=0, busy=0, config_done=0, config_error=0, write_index=0
  - the I2C master is reset by the same reset_n

## Timing
- Changes in state and outputs occur on the clk rising edge. All outputs are registered.
- i2c_go rises exactly POWERUP_CYCLES+1 cycles after the first cycle in which start=1 is sampled in IDLE.
- i2c_done -> next i2c_go takes GAP_CYCLES+2 cycles: the WAIT exit cycle, GAP_CYCLES, then ISSUE.
- Timeout: TIMEOUT_CYCLES cycles in WAIT with no i2c_done. If i2c_done arrives in the same cycle as expiry, i2c_done wins.
- i2c_data and write_index change only on WAIT exit. Both are stable throughout ISSUE/WAIT.
- config_done rises the cycle after the final successful i2c_done.
- hpd latency: 2 sync flops plus 1 edge-detect cycle, then the state becomes PWRUP.

## Test plan
- Nominal flow:
  - Stimulus: start=1; the I2C model acks every transaction after 50 cycles.
  - Required response: exactly 10 i2c_go pulses with i2c_data 72_41_10 … 72_15_00 in order; spacing per the Timing section; config_done=1; busy=0.
- Single NACK:
  - Stimulus: entry 3 (9C) NACKs once.
  - Required response: 72_9C_30 issued twice; 11 go pulses total; config_done=1.
- Persistent NACK:
  - Stimulus: entry 5 NACKs always.
  - Required response: 72_A2_A4 issued 4 times; then config_error=1 with write_index=5; no further i2c_go.
- Timeout:
  - Stimulus: the model never returns i2c_done on entry 0.
  - Required response: re-issue occurs after TIMEOUT_CYCLES+GAP_CYCLES+1 cycles; config_error after 4 attempts.
- Reset mid-WAIT:
  - Stimulus: reset_n=0 for 1 cycle at entry 7.
  - Required response: all outputs 0 on the next cycle; state IDLE; a new start replays from entry 0 with the full power-up delay.
- Hot-plug:
  - Stimulus: toggle hpd 0->1 in DONE.
  - Required response: busy rises 3 cycles later; the full 10-write sequence repeats; an hpd toggle during the sequence has no effect.
